seq_muldiv_unit: RTL and testbench

Parametrised sequential signed/unsigned multiply-and-divide engine. It is the next generation of the board-level multiplier core and adds a runtime divide mode, a configurable operand width, unsigned operation and a divide-by-zero flag. Results leave the block as sign-and-magnitude: a magnitude bus plus sign flags, which feeds the binary-to-BCD and digit-shifter display path directly. It runs on the fast system clock; start comes from a debounced button domain already synchronised to clk.

---
 rtl/seq_muldiv_unit_pkg.sv | 21 ++
 rtl/seq_muldiv_unit_abs_split.sv | 21 ++
 rtl/seq_muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_seq_muldiv_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_muldiv_unit_pkg.sv
// Shared definitions for the sequential multiply/divide engine: FSM state
// encoding, operation encoding and the legal operand width range.
package seq_muldiv_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

  function automatic bit width_legal(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/seq_muldiv_unit_abs_split.sv
// Splits a WIDTH-bit operand into a sign flag and an unsigned magnitude.
// The most negative value maps to 2^(WIDTH-1), which still fits in WIDTH
// bits when the magnitude is read as unsigned.
module seq_abs_split
  import seq_muldiv_unit_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic [WIDTH-1:0] value,
  output logic             sign,
  output logic [WIDTH-1:0] mag
);

  // Sign comes from the MSB only for two's complement operands.
  always_comb begin
    sign = SIGNED ? value[WIDTH-1] : 1'b0;
    mag  = sign ? (~value + WIDTH'(1)) : value;
  end

endmodule

// File: rtl/seq_muldiv_unit.sv
// Sequential sign-and-magnitude multiply/divide engine. Operands are reduced
// to magnitudes on start, processed one bit per cycle (shift-add multiply or
// restoring divide), and the signs are re-applied as flags on completion so
// the result bus feeds the BCD display path without further conversion.
module seq_muldiv_unit
  import seq_muldiv_unit_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               is_done,
  output logic               done_pulse,
  output logic [2*WIDTH-1:0] result,
  output logic               is_neg,
  output logic               rem_neg,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  generate
    if (!width_legal(WIDTH)) begin : g_width_check
      $error("seq_muldiv_unit: WIDTH %0d outside legal range", WIDTH);
    end
  endgenerate

  state_t             state;
  logic               op_q;
  logic               sign_a_q;
  logic               sign_b_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic [WIDTH:0]     shifted_rem;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] div_next;
  logic               quo_nz;
  logic               rem_nz;
  logic               prod_nz;
  logic               dbz_now;

  seq_abs_split #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_abs_a (
    .value (in_a),
    .sign  (sign_a),
    .mag   (mag_a)
  );

  seq_abs_split #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_abs_b (
    .value (in_b),
    .sign  (sign_b),
    .mag   (mag_b)
  );

  // One restoring-division step on {rem, quo}; mplier holds the divisor.
  always_comb begin
    shifted_rem = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial       = shifted_rem - {1'b0, mplier};
    if (trial[WIDTH]) begin
      div_next = {shifted_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // Zero detection so that a zero magnitude never shows as negative.
  always_comb begin
    quo_nz  = |acc[WIDTH-1:0];
    rem_nz  = |acc[2*WIDTH-1:WIDTH];
    prod_nz = |acc;
    dbz_now = (op_q == OP_DIV) && (mplier == '0);
  end

  // Control FSM and datapath: latch on start, iterate WIDTH times, publish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= OP_MUL;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      cnt         <= '0;
      is_done     <= 1'b1;
      done_pulse  <= 1'b0;
      result      <= '0;
      is_neg      <= 1'b0;
      rem_neg     <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            sign_a_q <= sign_a;
            sign_b_q <= sign_b;
            mplier   <= mag_b;
            mcand    <= {{WIDTH{1'b0}}, mag_a};
            acc      <= (op == OP_DIV) ? {{WIDTH{1'b0}}, mag_a} : '0;
            cnt      <= CW'(WIDTH);
            is_done  <= 1'b0;
            state    <= ((op == OP_DIV) && (mag_b == '0)) ? FINISH : RUN;
          end
        end
        RUN: begin
          if (op_q == OP_DIV) begin
            acc <= div_next;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FINISH;
        end
        FINISH: begin
          if (dbz_now) begin
            result      <= {acc[WIDTH-1:0], {WIDTH{1'b1}}};
            is_neg      <= 1'b0;
            rem_neg     <= 1'b0;
            div_by_zero <= 1'b1;
          end else if (op_q == OP_DIV) begin
            result      <= acc;
            is_neg      <= (sign_a_q ^ sign_b_q) && quo_nz;
            rem_neg     <= sign_a_q && rem_nz;
            div_by_zero <= 1'b0;
          end else begin
            result      <= acc;
            is_neg      <= (sign_a_q ^ sign_b_q) && prod_nz;
            rem_neg     <= 1'b0;
            div_by_zero <= 1'b0;
          end
          done_pulse <= 1'b1;
          is_done    <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Self-checking bench for seq_muldiv_unit: a WIDTH=8 signed instance driven
// from a vector table plus random traffic through a scoreboard, and small
// hand sequences for unsigned, WIDTH=12, back-to-back and mid-run reset.
module tb_seq_muldiv_unit;

  typedef struct {
    logic [31:0] result;
    bit          neg;
    bit          rem_neg;
    bit          dbz;
  } exp_t;

  typedef struct {
    bit          op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] result;
    bit          neg;
    bit          rem_neg;
    bit          dbz;
    int          busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start = 1'b0;
  logic        op    = 1'b0;
  logic [7:0]  in_a  = '0;
  logic [7:0]  in_b  = '0;
  logic        is_done, done_pulse, is_neg, rem_neg, div_by_zero;
  logic [15:0] result;

  logic        start_u = 1'b0;
  logic        op_u    = 1'b0;
  logic [7:0]  in_a_u  = '0;
  logic [7:0]  in_b_u  = '0;
  logic        is_done_u, done_pulse_u, is_neg_u, rem_neg_u, div_by_zero_u;
  logic [15:0] result_u;

  logic        start_w = 1'b0;
  logic        op_w    = 1'b0;
  logic [11:0] in_a_w  = '0;
  logic [11:0] in_b_w  = '0;
  logic        is_done_w, done_pulse_w, is_neg_w, rem_neg_w, div_by_zero_w;
  logic [23:0] result_w;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pulses = 0;
  exp_t sb_q[$];

  seq_muldiv_unit #(.WIDTH(8), .SIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
    .is_done(is_done), .done_pulse(done_pulse), .result(result),
    .is_neg(is_neg), .rem_neg(rem_neg), .div_by_zero(div_by_zero)
  );

  seq_muldiv_unit #(.WIDTH(8), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .start(start_u), .op(op_u), .in_a(in_a_u), .in_b(in_b_u),
    .is_done(is_done_u), .done_pulse(done_pulse_u), .result(result_u),
    .is_neg(is_neg_u), .rem_neg(rem_neg_u), .div_by_zero(div_by_zero_u)
  );

  seq_muldiv_unit #(.WIDTH(12), .SIGNED(1'b1)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .op(op_w), .in_a(in_a_w), .in_b(in_b_w),
    .is_done(is_done_w), .done_pulse(done_pulse_w), .result(result_w),
    .is_neg(is_neg_w), .rem_neg(rem_neg_w), .div_by_zero(div_by_zero_w)
  );

  always #5 clk = ~clk;

  // Hard stop in case a bounded wait is ever bypassed.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model in plain integer arithmetic (truncating division).
  function automatic exp_t model(input bit mop, input int a_raw, input int b_raw,
                                 input int w, input bit sgn);
    exp_t   e;
    int     a, b, q, r, aa, qa, ra;
    longint p;
    a = (sgn && a_raw >= (1 << (w - 1))) ? a_raw - (1 << w) : a_raw;
    b = (sgn && b_raw >= (1 << (w - 1))) ? b_raw - (1 << w) : b_raw;
    e = '{default: 0};
    if (!mop) begin
      p = longint'(a) * longint'(b);
      e.neg = (p < 0);
      e.result = 32'((p < 0) ? -p : p);
    end else if (b == 0) begin
      aa = (a < 0) ? -a : a;
      e.result = 32'((aa << w) | ((1 << w) - 1));
      e.dbz = 1'b1;
    end else begin
      q  = a / b;
      r  = a % b;
      qa = (q < 0) ? -q : q;
      ra = (r < 0) ? -r : r;
      e.result  = 32'((ra << w) | qa);
      e.neg     = (q < 0);
      e.rem_neg = (r < 0);
    end
    return e;
  endfunction

  // Scoreboard: every completion of the main instance is compared to the
  // oldest expected record.
  always @(negedge clk) begin
    if (done_pulse) begin
      n_pulses++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL unexpected_done: got done_pulse=1, expected no completion");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("result", {16'h0, result}, e.result);
        checkOutput("is_neg", {31'h0, is_neg}, {31'h0, e.neg});
        checkOutput("rem_neg", {31'h0, rem_neg}, {31'h0, e.rem_neg});
        checkOutput("div_by_zero", {31'h0, div_by_zero}, {31'h0, e.dbz});
      end
    end
  end

  // Starts one operation on the main instance and counts busy cycles.
  task automatic applyStimulus(input bit mop, input logic [7:0] a, input logic [7:0] b,
                               output int busy);
    int pulses_before;
    pulses_before = n_pulses;
    start = 1'b1;
    op    = mop;
    in_a  = a;
    in_b  = b;
    @(posedge clk);
    #1 start = 1'b0;
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (is_done) break;
      busy++;
    end
    if (!is_done) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL timeout: got is_done=0, expected 1 within 100 cycles");
    end
    #1;
    checkOutput("done_pulses", 32'(n_pulses - pulses_before), 32'd1);
  endtask

  task automatic applyStimulusU(input bit mop, input logic [7:0] a, input logic [7:0] b,
                                output int busy);
    start_u = 1'b1;
    op_u    = mop;
    in_a_u  = a;
    in_b_u  = b;
    @(posedge clk);
    #1 start_u = 1'b0;
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (is_done_u) break;
      busy++;
    end
    checkOutput("u_done_pulse", {31'h0, done_pulse_u}, 32'd1);
  endtask

  task automatic applyStimulusW(input bit mop, input logic [11:0] a, input logic [11:0] b,
                                output int busy);
    start_w = 1'b1;
    op_w    = mop;
    in_a_w  = a;
    in_b_w  = b;
    @(posedge clk);
    #1 start_w = 1'b0;
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (is_done_w) break;
      busy++;
    end
    checkOutput("w_done_pulse", {31'h0, done_pulse_w}, 32'd1);
  endtask

  // Main test sequence.
  initial begin
    vec_t vecs[13];
    int   busy;
    int   pulses_before;
    exp_t e;

    vecs[0]  = '{1'b0, 8'hFB, 8'h07, 32'h0023, 1'b1, 1'b0, 1'b0, 9};
    vecs[1]  = '{1'b0, 8'h80, 8'h80, 32'h4000, 1'b0, 1'b0, 1'b0, 9};
    vecs[2]  = '{1'b0, 8'h00, 8'hFD, 32'h0000, 1'b0, 1'b0, 1'b0, 9};
    vecs[3]  = '{1'b1, 8'h9C, 8'h07, 32'h020E, 1'b1, 1'b1, 1'b0, 9};
    vecs[4]  = '{1'b1, 8'h80, 8'hFF, 32'h0080, 1'b0, 1'b0, 1'b0, 9};
    vecs[5]  = '{1'b1, 8'h32, 8'h00, 32'h32FF, 1'b0, 1'b0, 1'b1, 1};
    vecs[6]  = '{1'b0, 8'h02, 8'h03, 32'h0006, 1'b0, 1'b0, 1'b0, 9};
    vecs[7]  = '{1'b1, 8'h07, 8'hFE, 32'h0103, 1'b1, 1'b0, 1'b0, 9};
    vecs[8]  = '{1'b1, 8'hF9, 8'h02, 32'h0103, 1'b1, 1'b1, 1'b0, 9};
    vecs[9]  = '{1'b1, 8'h03, 8'h05, 32'h0300, 1'b0, 1'b0, 1'b0, 9};
    vecs[10] = '{1'b1, 8'hFD, 8'h05, 32'h0300, 1'b0, 1'b1, 1'b0, 9};
    vecs[11] = '{1'b0, 8'h7F, 8'hFF, 32'h007F, 1'b1, 1'b0, 1'b0, 9};
    vecs[12] = '{1'b1, 8'h80, 8'h00, 32'h80FF, 1'b0, 1'b0, 1'b1, 1};

    #12;
    checkOutput("reset_is_done", {31'h0, is_done}, 32'd1);
    checkOutput("reset_done_pulse", {31'h0, done_pulse}, 32'd0);
    checkOutput("reset_result", {16'h0, result}, 32'd0);
    checkOutput("reset_flags", {29'h0, is_neg, rem_neg, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] table vectors");
    foreach (vecs[i]) begin
      sb_q.push_back('{vecs[i].result, vecs[i].neg, vecs[i].rem_neg, vecs[i].dbz});
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, busy);
      checkOutput($sformatf("busy_vec%0d", i), 32'(busy), 32'(vecs[i].busy));
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 24; i++) begin
      bit         rop;
      logic [7:0] ra, rb;
      rop = 1'($urandom_range(0, 1));
      ra  = 8'($urandom_range(0, 255));
      rb  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      sb_q.push_back(model(rop, int'(ra), int'(rb), 8, 1'b1));
      applyStimulus(rop, ra, rb, busy);
      checkOutput("busy_rand", 32'(busy), (rop && rb == 8'h00) ? 32'd1 : 32'd9);
    end

    $display("[TB] start held high with operand change during RUN");
    pulses_before = n_pulses;
    sb_q.push_back(model(1'b0, 3, 4, 8, 1'b1));
    sb_q.push_back(model(1'b0, 100, 4, 8, 1'b1));
    start = 1'b1;
    op    = 1'b0;
    in_a  = 8'd3;
    in_b  = 8'd4;
    @(posedge clk);
    #1 in_a = 8'd100;
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (is_done) break;
      busy++;
    end
    checkOutput("b2b_busy1", 32'(busy), 32'd9);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("b2b_restart", {31'h0, is_done}, 32'd0);
    busy = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (is_done) break;
      busy++;
    end
    checkOutput("b2b_busy2", 32'(busy), 32'd9);
    #1;
    checkOutput("b2b_pulses", 32'(n_pulses - pulses_before), 32'd2);

    $display("[TB] unsigned WIDTH=8 instance");
    checkOutput("u_reset_result", {16'h0, result_u}, 32'd0);
    applyStimulusU(1'b0, 8'd200, 8'd255, busy);
    checkOutput("u_mul_result", {16'h0, result_u}, 32'd51000);
    checkOutput("u_mul_is_neg", {31'h0, is_neg_u}, 32'd0);
    checkOutput("u_mul_busy", 32'(busy), 32'd9);
    applyStimulusU(1'b1, 8'd200, 8'd7, busy);
    checkOutput("u_div_result", {16'h0, result_u}, 32'h041C);
    checkOutput("u_div_flags", {30'h0, is_neg_u, rem_neg_u}, 32'd0);

    $display("[TB] signed WIDTH=12 instance");
    applyStimulusW(1'b0, 12'h800, 12'h7FF, busy);
    checkOutput("w_mul_result", {8'h0, result_w}, 32'd4192256);
    checkOutput("w_mul_is_neg", {31'h0, is_neg_w}, 32'd1);
    checkOutput("w_mul_busy", 32'(busy), 32'd13);
    e = model(1'b1, 12'hC18, 12'h00D, 12, 1'b1);
    applyStimulusW(1'b1, 12'hC18, 12'h00D, busy);
    checkOutput("w_div_result", {8'h0, result_w}, e.result);
    checkOutput("w_div_flags", {30'h0, is_neg_w, rem_neg_w}, {30'h0, e.neg, e.rem_neg});

    $display("[TB] reset during multiply");
    pulses_before = n_pulses;
    start = 1'b1;
    op    = 1'b0;
    in_a  = 8'hFB;
    in_b  = 8'h07;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_is_done", {31'h0, is_done}, 32'd1);
    checkOutput("abort_result", {16'h0, result}, 32'd0);
    checkOutput("abort_flags", {29'h0, is_neg, rem_neg, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    checkOutput("abort_no_pulse", 32'(n_pulses - pulses_before), 32'd0);
    checkOutput("abort_idle", {31'h0, is_done}, 32'd1);
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
